// File: rtl/bcd_event_counter_pkg.sv
// -----------------------------------------------------------------------------
// bcd_event_counter_pkg
// Shared constants and helpers for the BCD event counter and its per-decade
// digit cell.
//   BCD_MAX       largest legal decimal digit
//   ERR_CODE_DEF  default nibble shown on every digit while in error state
//   is_bcd()      returns 1 when a nibble holds a legal decimal digit (0..9)
// -----------------------------------------------------------------------------
package bcd_event_counter_pkg;

   localparam logic [3:0] BCD_MAX      = 4'd9;
   localparam logic [3:0] ERR_CODE_DEF = 4'hE;

   function automatic logic is_bcd(input logic [3:0] nibble);
      return (nibble <= BCD_MAX);
   endfunction

endpackage : bcd_event_counter_pkg

// File: rtl/bcd_event_counter_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One decade of the BCD counter. It holds a single digit in the range 0..9
// and steps it when the chain says so.
//
// Ports:
//   clk_i       system clock
//   rst_i       synchronous reset, active-high (digit -> 0)
//   clr_i       synchronous clear (digit -> 0)
//   load_i      load strobe, only asserted by the top for a fully valid word
//   load_val_i  digit value to load
//   en_i        commit enable for a step; low when the step is being refused
//   cin_i       carry-in: an increment reaches this decade
//   bin_i       borrow-in: a decrement reaches this decade
//   digit_o     current digit value
//   cout_o      carry-out  (carry-in and digit == 9)
//   bout_o      borrow-out (borrow-in and digit == 0)
// -----------------------------------------------------------------------------
module bcd_digit
   import bcd_event_counter_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clr_i,
   input  logic       load_i,
   input  logic [3:0] load_val_i,
   input  logic       en_i,
   input  logic       cin_i,
   input  logic       bin_i,
   output logic [3:0] digit_o,
   output logic       cout_o,
   output logic       bout_o
);

   logic [3:0] digit_q;
   logic [3:0] digit_d;

   // Carry/borrow terms ignore en_i so the top can see "at max"/"at zero"
   // before deciding whether the step is allowed to commit.
   assign cout_o  = cin_i && (digit_q == BCD_MAX);
   assign bout_o  = bin_i && (digit_q == 4'd0);
   assign digit_o = digit_q;

   always_comb begin
      digit_d = digit_q;
      if (clr_i) begin
         digit_d = 4'd0;
      end else if (load_i) begin
         digit_d = load_val_i;
      end else if (en_i && cin_i) begin
         digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
      end else if (en_i && bin_i) begin
         digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         digit_q <= 4'd0;
      end else begin
         digit_q <= digit_d;
      end
   end

endmodule : bcd_digit

// File: rtl/bcd_event_counter.sv
// -----------------------------------------------------------------------------
// bcd_event_counter
// N-digit BCD up/down event counter with parallel load, clear, and either
// modulo wrap or saturate-with-error behaviour at the range ends.
//
// Parameters:
//   DIGITS    number of decades (1..8)
//   WRAP      1 = wrap at range ends, 0 = hold and enter error state
//   ERR_CODE  nibble shown on every digit while in error state
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous reset, active-high, highest priority
//   clr_i        clear count and error state
//   load_i       load strobe for load_data_i
//   load_data_i  BCD load word, digit k at [4k+3:4k], digit 0 least significant
//   inc_i        single-cycle increment event
//   dec_i        single-cycle decrement event
//   bcd_o        current digits, or ERR_CODE on all digits in error state
//   err_o        sticky error flag (never set when WRAP=1)
//   ovf_o        one-cycle pulse: increment issued at maximum
//   unf_o        one-cycle pulse: decrement issued at zero
//   load_err_o   one-cycle pulse: load rejected due to a non-BCD digit
// -----------------------------------------------------------------------------
module bcd_event_counter
   import bcd_event_counter_pkg::*;
#(
   parameter int         DIGITS   = 2,
   parameter bit         WRAP     = 1'b0,
   parameter logic [3:0] ERR_CODE = ERR_CODE_DEF
)
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clr_i,
   input  logic                  load_i,
   input  logic [4*DIGITS-1:0]   load_data_i,
   input  logic                  inc_i,
   input  logic                  dec_i,
   output logic [4*DIGITS-1:0]   bcd_o,
   output logic                  err_o,
   output logic                  ovf_o,
   output logic                  unf_o,
   output logic                  load_err_o
);

   logic [4*DIGITS-1:0] count;
   logic [DIGITS:0]     carry;
   logic [DIGITS:0]     borrow;

   logic all_valid;
   logic load_ok;
   logic inc_req;
   logic dec_req;
   logic at_limit;
   logic step_en;

   logic err_q,      err_d;
   logic ovf_q,      ovf_d;
   logic unf_q,      unf_d;
   logic load_err_q, load_err_d;

   always_comb begin
      all_valid = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (!is_bcd(load_data_i[4*k +: 4])) begin
            all_valid = 1'b0;
         end
      end
   end

   assign load_ok = load_i && !clr_i && all_valid;

   // Simultaneous inc/dec cancel. Steps are also blocked by clear, any load
   // (even a rejected one) and the error state.
   assign inc_req = inc_i && !dec_i && !clr_i && !load_i && !err_q;
   assign dec_req = dec_i && !inc_i && !clr_i && !load_i && !err_q;

   assign carry[0]  = inc_req;
   assign borrow[0] = dec_req;

   // A carry/borrow falling off the top decade means every digit was 9 (inc)
   // or 0 (dec), i.e. the AND of all per-digit terms.
   assign ovf_d    = carry[DIGITS];
   assign unf_d    = borrow[DIGITS];
   assign at_limit = ovf_d || unf_d;

   // In wrap mode the digits roll over naturally; otherwise the step is refused.
   assign step_en = WRAP ? 1'b1 : !at_limit;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .clr_i      (clr_i),
         .load_i     (load_ok),
         .load_val_i (load_data_i[4*g +: 4]),
         .en_i       (step_en),
         .cin_i      (carry[g]),
         .bin_i      (borrow[g]),
         .digit_o    (count[4*g +: 4]),
         .cout_o     (carry[g+1]),
         .bout_o     (borrow[g+1])
      );
   end

   always_comb begin
      err_d = err_q;
      if (clr_i || load_ok) begin
         err_d = 1'b0;
      end else if (!WRAP && at_limit) begin
         err_d = 1'b1;
      end
   end

   assign load_err_d = load_i && !clr_i && !all_valid;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q      <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         err_q      <= err_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         load_err_q <= load_err_d;
      end
   end

   // The count is kept intact underneath the error display.
   assign bcd_o      = err_q ? {DIGITS{ERR_CODE}} : count;
   assign err_o      = err_q;
   assign ovf_o      = ovf_q;
   assign unf_o      = unf_q;
   assign load_err_o = load_err_q;

endmodule : bcd_event_counter
